// File: rtl/mosi_cmd_sequencer.sv
// Multi-bank MOSI command RAM with a built-in list sequencer for the SPI side.
// The host loads and reads back any bank; bank swaps take effect only at list wrap or start.
module mosi_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_BANKS  = 2,
  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [BANK_BITS-1:0]  wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  input  logic                  seq_start,
  input  logic                  seq_stop,
  input  logic                  seq_step,
  input  logic [ADDR_WIDTH-1:0] seq_max_index,
  input  logic [BANK_BITS-1:0]  bank_sel,
  input  logic                  bank_swap_req,
  output logic [DATA_WIDTH-1:0] cmd_out,
  output logic                  cmd_valid,
  output logic [ADDR_WIDTH-1:0] seq_index,
  output logic                  list_wrap,
  output logic [BANK_BITS-1:0]  active_bank,
  output logic                  swap_pending,
  output logic                  running
);

  localparam int unsigned MEM_AW = BANK_BITS + ADDR_WIDTH;
  localparam int unsigned DEPTH  = 1 << MEM_AW;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [MEM_AW-1:0]     host_addr, fetch_addr;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch, wrap;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic [BANK_BITS-1:0]  fetch_bank, apply_bank, bank_d, swap_target, target_d;
  logic                  pend_d;

  assign host_addr  = {wr_bank, wr_addr};
  assign fetch_addr = {fetch_bank, fetch_idx};

  // Host write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[host_addr] <= wr_data;
  end

  // Sequencer read with write-first bypass on a same-address host write.
  always_comb begin
    fetch_data = mem[fetch_addr];
    if (wr_en && (host_addr == fetch_addr)) fetch_data = wr_data;
  end

  // Next state, fetch decision and bank-swap bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch      = 1'b0;
    wrap       = 1'b0;
    fetch_idx  = '0;
    fetch_bank = active_bank;
    bank_d     = active_bank;
    pend_d     = swap_pending;
    target_d   = swap_target;
    // A request arriving on the applying cycle itself wins over an older pending one.
    apply_bank = bank_swap_req ? bank_sel : (swap_pending ? swap_target : active_bank);

    if (bank_swap_req) begin
      if (state_q == RUN) begin
        pend_d   = 1'b1;
        target_d = bank_sel;
      end else begin
        bank_d = bank_sel;
        pend_d = 1'b0;
      end
    end

    if (seq_stop) begin
      state_d = IDLE;
    end else if (seq_start || ((state_q == RUN) && seq_step)) begin
      state_d = RUN;
      fetch   = 1'b1;
      if (seq_start || (seq_index >= seq_max_index)) begin
        wrap       = !seq_start;
        fetch_bank = apply_bank;
        bank_d     = apply_bank;
        pend_d     = 1'b0;
      end else begin
        fetch_idx = seq_index + ADDR_WIDTH'(1);
      end
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      running      <= 1'b0;
      cmd_out      <= '0;
      cmd_valid    <= 1'b0;
      seq_index    <= '0;
      list_wrap    <= 1'b0;
      active_bank  <= '0;
      swap_pending <= 1'b0;
      swap_target  <= '0;
      host_rd_data <= '0;
    end else begin
      state_q      <= state_d;
      running      <= (state_d == RUN);
      cmd_valid    <= fetch;
      list_wrap    <= wrap;
      active_bank  <= bank_d;
      swap_pending <= pend_d;
      swap_target  <= target_d;
      if (fetch) begin
        cmd_out   <= fetch_data;
        seq_index <= fetch_idx;
      end
      host_rd_data <= wr_en ? wr_data : mem[host_addr];
    end
  end

endmodule

// File: doc/mosi_cmd_sequencer.md
Name: mosi_cmd_sequencer

Overview:
Parametrised successor to the 1024x16 MOSI command RAM. It holds NUM_BANKS command lists and adds a built-in read sequencer, so the SPI side steps through a list with a single pulse instead of driving addresses. The host loads one bank while another runs; bank swaps take effect only at list wrap, which keeps each SPI sample cycle's command sequence coherent. It sits between the USB register/pipe logic (write side) and the RHD2000 SPI state machine (command side), all on one clock.

Parameters:
DATA_WIDTH, 16, command word width.
ADDR_WIDTH, 10, index width per bank; bank depth = 2**ADDR_WIDTH.
NUM_BANKS, 2, number of command lists. Must be a power of two and >= 2. BANK_BITS = clog2(NUM_BANKS).

Ports:
clk  in  1  single clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high.
wr_en  in  1  host write strobe.
wr_bank  in  BANK_BITS  host write/readback bank.
wr_addr  in  ADDR_WIDTH  host write/readback address.
wr_data  in  DATA_WIDTH  host write data.
host_rd_data  out  DATA_WIDTH  readback of [wr_bank][wr_addr]; 1-cycle latency.
seq_start  in  1  pulse: start or restart the sequence at index 0.
seq_stop  in  1  pulse: stop sequencing.
seq_step  in  1  pulse: fetch the next command.
seq_max_index  in  ADDR_WIDTH  last valid index of the list; sampled on every step.
bank_sel  in  BANK_BITS  requested bank.
bank_swap_req  in  1  pulse: request a switch to bank_sel.
cmd_out  out  DATA_WIDTH  current command word; held between fetches.
cmd_valid  out  1  1-cycle pulse when cmd_out updates.
seq_index  out  ADDR_WIDTH  index of the word on cmd_out.
list_wrap  out  1  1-cycle pulse, coincident with cmd_valid, when index 0 is presented after a wrap.
active_bank  out  BANK_BITS  bank used for sequencer fetches.
swap_pending  out  1  a swap request is latched but not yet applied.
running  out  1  high in RUN.

Behaviour:
- Reset (async assert, sync release): state IDLE. cmd_out, cmd_valid, seq_index, list_wrap, active_bank, swap_pending, running and host_rd_data all 0. RAM contents are not cleared. Asserting reset mid-run aborts immediately; there is no partial pulse afterwards.
- Memory: NUM_BANKS * 2**ADDR_WIDTH words. Host port: when wr_en is high, write on that edge. host_rd_data is registered and write-first, so same-cycle readback returns wr_data.
- States: IDLE and RUN.
  - IDLE -> RUN on seq_start.
  - RUN -> IDLE on seq_stop.
  - seq_stop has priority over seq_start and seq_step in the same cycle.
- Fetch: the sequencer reads [active_bank][index] on fetch cycle N. On N+1, cmd_out and seq_index update and cmd_valid = 1 for that cycle only.
- seq_start, in either state, fetches index 0:
  - if a swap is pending, apply it first; that fetch uses the new bank;
  - list_wrap = 0.
- seq_step in RUN:
  - if seq_index < seq_max_index, fetch seq_index + 1;
  - otherwise (equal, or greater because max was lowered mid-run), wrap: apply any pending swap, fetch index 0, assert list_wrap with that cmd_valid.
- seq_step in IDLE: ignored. seq_step in the same cycle as seq_start: start wins.
- Back-to-back steps every cycle are supported: one fetch per cycle, cmd_valid stays high continuously.
- seq_max_index = 0: every step rewraps to index 0, and list_wrap pulses on each step.
- Bank swap:
  - bank_swap_req in IDLE updates active_bank on the next edge; swap_pending stays 0.
  - In RUN it latches bank_sel and sets swap_pending; the swap is applied at the next wrap or start.
  - A new request while pending overwrites the target.
  - Requesting the current bank is still latched and applied; the result is a no-op bank change, but swap_pending is still cleared.
- Collision: a host write and a sequencer fetch to the same bank/address in the same cycle give write-first; cmd_out returns wr_data.
- No output is combinational from any input.

Test Plan:
1. Reset and basic fetch: reset, write bank0[0..3] = 16'hA000..A003, max = 3, pulse start, then 4 steps.
   Required: cmd_out sequence A000, A001, A002, A003, A000. list_wrap high only on the 5th cmd_valid. seq_index 0, 1, 2, 3, 0.
2. Deferred swap: bank1[0] = 16'hB000, running in bank0 at index 1, swap_req with bank_sel = 1.
   Required: swap_pending = 1, active_bank stays 0 until wrap. The wrap fetch returns B000 with active_bank = 1 and swap_pending = 0.
3. Priority: start + stop in the same cycle -> stays IDLE, no cmd_valid. Start + step in the same cycle -> index 0 presented, no list_wrap.
4. Collision: while running, write bank0[2] = 16'h1234 in the same cycle the step fetches index 2.
   Required: cmd_out = 1234. host_rd_data = 1234 one cycle later.
5. Max lowered mid-run: at seq_index 5, set max = 2 and step.
   Required: index 0 presented with list_wrap = 1. Separately, max = 0 with continuous steps gives cmd_valid every cycle, index fixed at 0, list_wrap every cycle.
6. Async reset mid-run at index 7.
   Required: on the same edge running = 0, cmd_out = 0, active_bank = 0. RAM still holds the written data, verified by host readback.
